// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - five-state instruction sequencer driving bus, stack and ALU strobes
module control_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    input  logic [0:18] i_instr,
    input  logic        i_carry,
    output logic [16:0] o_instrAddr,
    output logic [16:0] o_busData,
    output logic        o_busDrive,
    output logic        o_aluDrive,
    output logic        o_stkS,
    output logic        o_stkW,
    output logic [2:0]  o_spCtrl,
    output logic [5:0]  o_aluOP,
    output logic        o_carryWriteCtrl,
    output logic        o_halted
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC1  = 3'd2,
        EXEC2  = 3'd3,
        HALTED = 3'd4
    } state_t;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSHI = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_ALU   = 3'b011;
    localparam logic [2:0] OP_JMP   = 3'b100;
    localparam logic [2:0] OP_JC    = 3'b101;
    localparam logic [2:0] OP_HALT  = 3'b110;

    state_t      state;
    logic [0:18] ir;
    logic [16:0] pc;
    logic [2:0]  opcode;
    logic [16:0] imm;
    logic [16:0] pcInc;

    assign opcode      = ir[0:2];
    assign imm         = {1'b0, ir[3:18]};
    assign pcInc       = pc + 17'd1;
    assign o_instrAddr = pc;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            pc    <= '0;
            ir    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_run) state <= FETCH;
                end
                FETCH: begin
                    ir    <= i_instr;
                    state <= EXEC1;
                end
                EXEC1: begin
                    case (opcode)
                        OP_PUSHI: state <= EXEC2;
                        OP_JMP: begin
                            pc    <= imm;
                            state <= FETCH;
                        end
                        OP_JC: begin
                            pc    <= i_carry ? imm : pcInc;
                            state <= FETCH;
                        end
                        OP_HALT: state <= HALTED;
                        default: begin
                            // NOP, POP, ALU and the spare opcode all just advance
                            pc    <= pcInc;
                            state <= FETCH;
                        end
                    endcase
                end
                EXEC2: begin
                    pc    <= pcInc;
                    state <= FETCH;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes come only from flopped state and IR, so reset clears them at once
    always_comb begin
        o_busData        = '0;
        o_busDrive       = 1'b0;
        o_aluDrive       = 1'b0;
        o_stkS           = 1'b0;
        o_stkW           = 1'b0;
        o_spCtrl         = 3'b000;
        o_aluOP          = '0;
        o_carryWriteCtrl = 1'b0;
        o_halted         = (state == HALTED);
        if (state == EXEC1) begin
            case (opcode)
                OP_PUSHI: begin
                    o_busDrive = 1'b1;
                    o_busData  = imm;
                    o_stkS     = 1'b1;
                    o_stkW     = 1'b1;
                    o_spCtrl   = 3'b100;
                end
                OP_POP: o_spCtrl = 3'b001;
                OP_ALU: begin
                    o_aluOP          = ir[3:8];
                    o_aluDrive       = 1'b1;
                    o_stkS           = 1'b1;
                    o_stkW           = 1'b1;
                    o_spCtrl         = 3'b100;
                    o_carryWriteCtrl = 1'b1;
                end
                default: ;
            endcase
        end else if (state == EXEC2 && opcode == OP_PUSHI) begin
            o_spCtrl = 3'b010;
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed bench for control_sequencer against a small program ROM
module tb_control_sequencer;

    logic        i_clk;
    logic        i_rst;
    logic        i_run;
    logic [0:18] i_instr;
    logic        i_carry;
    logic [16:0] o_instrAddr;
    logic [16:0] o_busData;
    logic        o_busDrive;
    logic        o_aluDrive;
    logic        o_stkS;
    logic        o_stkW;
    logic [2:0]  o_spCtrl;
    logic [5:0]  o_aluOP;
    logic        o_carryWriteCtrl;
    logic        o_halted;

    int tests = 0;
    int fails = 0;

    control_sequencer dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_run            (i_run),
        .i_instr          (i_instr),
        .i_carry          (i_carry),
        .o_instrAddr      (o_instrAddr),
        .o_busData        (o_busData),
        .o_busDrive       (o_busDrive),
        .o_aluDrive       (o_aluDrive),
        .o_stkS           (o_stkS),
        .o_stkW           (o_stkW),
        .o_spCtrl         (o_spCtrl),
        .o_aluOP          (o_aluOP),
        .o_carryWriteCtrl (o_carryWriteCtrl),
        .o_halted         (o_halted)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [0:18] mk(input logic [2:0] op, input logic [15:0] val);
        logic [0:18] w;
        w = {op, val};
        return w;
    endfunction

    // Program ROM; every unlisted address reads as NOP
    function automatic logic [0:18] romAt(input logic [16:0] a);
        case (a)
            17'h00000: return mk(3'b001, 16'h1234);
            17'h00001: return mk(3'b011, {6'h09, 10'h000});
            17'h00002: return mk(3'b101, 16'h0040);
            17'h00003: return mk(3'b101, 16'h0040);
            17'h00005: return mk(3'b110, 16'h0000);
            17'h00040: return mk(3'b010, 16'h0000);
            17'h00041: return mk(3'b111, 16'hFFFF);
            17'h00042: return mk(3'b100, 16'h0005);
            default:   return mk(3'b000, 16'h0000);
        endcase
    endfunction

    always_comb i_instr = romAt(o_instrAddr);

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Expected fields: busDrive aluDrive stkS stkW spCtrl aluOP carryW halted busData instrAddr
    task automatic chk(input string tag, input logic bd, input logic ad, input logic s,
                       input logic w, input logic [2:0] sp, input logic [5:0] op,
                       input logic cw, input logic h, input logic [16:0] data,
                       input logic [16:0] addr);
        logic [63:0] obs;
        logic [63:0] exp;
        obs = {15'h0, o_busDrive, o_aluDrive, o_stkS, o_stkW, o_spCtrl, o_aluOP,
               o_carryWriteCtrl, o_halted, o_busData, o_instrAddr};
        exp = {15'h0, bd, ad, s, w, sp, op, cw, h, data, addr};
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_run   = 1'b0;
        i_carry = 1'b0;
        tick();
        tick();
        chk("reset_state", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        tick();
        tick();
        chk("idle_wait", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h0);

        i_run = 1'b1;
        tick();
        chk("pushi_fetch", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h0);
        i_run = 1'b0;
        tick();
        chk("pushi_exec1", 1, 0, 1, 1, 3'b100, 6'h00, 0, 0, 17'h01234, 17'h0);
        tick();
        chk("pushi_exec2", 0, 0, 0, 0, 3'b010, 6'h00, 0, 0, 17'h0, 17'h0);
        tick();
        chk("alu_fetch", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h1);
        tick();
        chk("alu_exec1", 0, 1, 1, 1, 3'b100, 6'h09, 1, 0, 17'h0, 17'h1);
        tick();
        chk("jc0_fetch", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h2);
        tick();
        chk("jc0_exec1", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h2);
        tick();
        chk("jc0_next", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h3);
        i_carry = 1'b1;
        tick();
        chk("jc1_exec1", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h3);
        tick();
        chk("jc1_next", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h40);
        i_carry = 1'b0;
        tick();
        chk("pop_exec1", 0, 0, 0, 0, 3'b001, 6'h00, 0, 0, 17'h0, 17'h40);
        tick();
        tick();
        chk("op111_exec1", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h41);
        tick();
        tick();
        chk("jmp_exec1", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h42);
        tick();
        chk("halt_fetch", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h5);
        tick();
        chk("halt_exec1", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h5);
        tick();
        chk("halted", 0, 0, 0, 0, 3'b000, 6'h00, 0, 1, 17'h0, 17'h5);
        for (int i = 0; i < 10; i++) begin
            i_run = ~i_run;
            tick();
            chk("halt_hold", 0, 0, 0, 0, 3'b000, 6'h00, 0, 1, 17'h0, 17'h5);
        end
        i_run = 1'b0;

        #2 i_rst = 1'b1;
        #1 chk("halt_reset", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h0);
        #1 i_rst = 1'b0;
        tick();
        tick();
        chk("post_halt_idle", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h0);

        force dut.pc = 17'h1FFFF;
        #1 release dut.pc;
        #1 chk("pc_preload", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h1FFFF);
        i_run = 1'b1;
        tick();
        i_run = 1'b0;
        chk("wrap_fetch", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h1FFFF);
        tick();
        chk("wrap_exec1", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h1FFFF);
        tick();
        chk("wrap_next", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h0);
        tick();
        chk("abort_exec1", 1, 0, 1, 1, 3'b100, 6'h00, 0, 0, 17'h01234, 17'h0);
        #2 i_rst = 1'b1;
        #1 chk("abort_drop", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h0);
        #1 i_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_after", 0, 0, 0, 0, 3'b000, 6'h00, 0, 0, 17'h0, 17'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
